// File: rtl/alu_mdu_control.sv
// alu_mdu_control: EX-stage ALU decode plus an iterative multiply/divide unit with HI/LO registers.
// Revision 1.0
`default_nettype none

module alu_mdu_control #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 4
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              ex_valid,
  input  logic              flush,
  input  logic [1:0]        alu_op,
  input  logic [5:0]        function_field,
  input  logic [DATA_W-1:0] operand_a,
  input  logic [DATA_W-1:0] operand_b,
  output logic [OP_W-1:0]   alu_control,
  output logic              mf_sel,
  output logic [DATA_W-1:0] mdu_result,
  output logic              stall,
  output logic              mdu_busy
);

  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [DATA_W-1:0] CNT_LAST = DATA_W'(DATA_W - 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_FIX = 2'd2} state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic [DATA_W-1:0]   acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d;
  logic [DATA_W-1:0]   b_q, b_d, a_raw_q, a_raw_d;
  logic                div_q, div_d, neg_q, neg_d, neg_a_q, neg_a_d;
  logic                done_q, done_d;

  logic              r_type, is_arith, is_mf, is_signed, a_neg, b_neg, start;
  logic [DATA_W-1:0] a_mag, b_mag;
  logic [DATA_W:0]   mul_sum, div_shift, div_diff;
  logic [2*DATA_W-1:0] prod_fix;

  assign r_type    = ex_valid & (alu_op == 2'd2);
  assign is_arith  = (function_field == F_MULT) | (function_field == F_MULTU) |
                     (function_field == F_DIV)  | (function_field == F_DIVU);
  assign is_mf     = (function_field == F_MFHI) | (function_field == F_MFLO);
  assign is_signed = ~function_field[0];
  assign a_neg     = is_signed & operand_a[DATA_W-1];
  assign b_neg     = is_signed & operand_b[DATA_W-1];
  assign a_mag     = a_neg ? -operand_a : operand_a;
  assign b_mag     = b_neg ? -operand_b : operand_b;

  // done_q covers the one cycle the finished instruction is still in EX, so it must not restart.
  assign start     = r_type & is_arith & (state_q == S_IDLE) & ~flush & ~done_q;
  assign mdu_busy  = (state_q != S_IDLE);
  assign stall     = r_type & (is_arith | is_mf) & (mdu_busy | start);
  assign mf_sel    = r_type & is_mf;

  always_comb begin
    mdu_result = '0;
    if (r_type && function_field == F_MFHI) mdu_result = hi_q;
    else if (r_type && function_field == F_MFLO) mdu_result = lo_q;
  end

  always_comb begin
    alu_control = '0;
    case (alu_op)
      2'd0: alu_control = OP_W'(2);
      2'd1: alu_control = OP_W'(5);
      2'd2: begin
        case (function_field)
          6'b100000: alu_control = OP_W'(2);
          6'b100010: alu_control = OP_W'(5);
          6'b100100: alu_control = OP_W'(0);
          6'b100101: alu_control = OP_W'(1);
          6'b100111: alu_control = OP_W'(12);
          6'b101010: alu_control = OP_W'(7);
          6'b000000: alu_control = OP_W'(3);
          6'b000010: alu_control = OP_W'(4);
          default:   alu_control = '0;
        endcase
      end
      default: alu_control = '0;
    endcase
  end

  // Multiply: {acc_hi,acc_lo} is the shift-add product register, multiplier in acc_lo.
  // Divide: acc_hi is the partial remainder, acc_lo shifts dividend out and quotient in.
  assign mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, b_q} : '0);
  assign div_shift = {acc_hi_q, acc_lo_q[DATA_W-1]};
  assign div_diff  = div_shift - {1'b0, b_q};
  assign prod_fix  = neg_q ? -{acc_hi_q, acc_lo_q} : {acc_hi_q, acc_lo_q};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    b_d      = b_q;
    a_raw_d  = a_raw_q;
    div_d    = div_q;
    neg_d    = neg_q;
    neg_a_d  = neg_a_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_RUN;
          cnt_d    = '0;
          acc_hi_d = '0;
          acc_lo_d = a_mag;
          b_d      = b_mag;
          a_raw_d  = operand_a;
          div_d    = function_field[1];
          neg_d    = a_neg ^ b_neg;
          neg_a_d  = a_neg;
        end
      end
      S_RUN: begin
        if (div_q) begin
          if (!div_diff[DATA_W]) begin
            acc_hi_d = div_diff[DATA_W-1:0];
            acc_lo_d = {acc_lo_q[DATA_W-2:0], 1'b1};
          end else begin
            acc_hi_d = div_shift[DATA_W-1:0];
            acc_lo_d = {acc_lo_q[DATA_W-2:0], 1'b0};
          end
        end else begin
          {acc_hi_d, acc_lo_d} = {mul_sum, acc_lo_q[DATA_W-1:1]};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = S_FIX;
          cnt_d   = '0;
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        if (!div_q) begin
          {hi_d, lo_d} = prod_fix;
        end else if (b_q == '0) begin
          lo_d = '1;
          hi_d = a_raw_q;
        end else begin
          lo_d = neg_q   ? -acc_lo_q : acc_lo_q;
          hi_d = neg_a_q ? -acc_hi_q : acc_hi_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (flush) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      b_q      <= '0;
      a_raw_q  <= '0;
      div_q    <= 1'b0;
      neg_q    <= 1'b0;
      neg_a_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      b_q      <= b_d;
      a_raw_q  <= a_raw_d;
      div_q    <= div_d;
      neg_q    <= neg_d;
      neg_a_q  <= neg_a_d;
      done_q   <= done_d;
    end
  end

endmodule

`default_nettype wire
